// File: rtl/placement_pkg.sv
// placement_pkg: shared types and defaults for the placement engine and its evaluator
package placement_pkg;
  localparam int DW_DEF = 32;
  localparam int GRID_N_DEF = 7;
  localparam int N_EDGE_DEF = 52;
  localparam int UNPLACED = -1;
  typedef enum logic [3:0] {IDLE, RD_E, W_E, RD_A, W_A, RD_B, W_B, CALC, ACC, DONE} state_t;
endpackage

// File: rtl/edge_cost.sv
// edge_cost: per-edge Manhattan distance, 1-hop length and legality of both endpoints
module edge_cost import placement_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int GRID_N = GRID_N_DEF
)(
  input  logic signed [DW-1:0] xa,
  input  logic signed [DW-1:0] ya,
  input  logic signed [DW-1:0] xb,
  input  logic signed [DW-1:0] yb,
  output logic signed [DW-1:0] dx,
  output logic signed [DW-1:0] dy,
  output logic signed [DW-1:0] len,
  output logic signed [DW-1:0] len_1hop,
  output logic illegal
);
  logic signed [DW-1:0] vx, vy;
  function automatic logic bad(input logic signed [DW-1:0] c);
    return c == DW'(UNPLACED) || c >= DW'(GRID_N);
  endfunction
  always_comb begin
    vx = xa - xb;
    vy = ya - yb;
    dx = vx < 0 ? (~vx) + DW'(1) : vx;
    dy = vy < 0 ? (~vy) + DW'(1) : vy;
    len = dx + dy;
    len_1hop = (dx >> 1) + DW'(dx[0]) + (dy >> 1) + DW'(dy[0]) - DW'(1);
    illegal = bad(xa) || bad(ya) || bad(xb) || bad(yb) || len == '0;
  end
endmodule

// File: rtl/placement_eval.sv
// placement_eval: walks edge/position memories and totals wirelength after placement.
// Define PLACEMENT_EVAL_HIST_EN to add an 8-bin edge-length histogram (hist_sel/hist_cnt).
module placement_eval import placement_pkg::*; #(
  parameter int N_EDGE = N_EDGE_DEF,
  parameter int GRID_N = GRID_N_DEF,
  parameter int EDGE_AW = 8,
  parameter int POS_AW = 7,
  parameter int DW = DW_DEF
)(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic edge_re,
  output logic [EDGE_AW-1:0] edge_addr,
  input  logic signed [DW-1:0] edge_a,
  input  logic signed [DW-1:0] edge_b,
  output logic pos_re,
  output logic [POS_AW-1:0] pos_addr,
  input  logic signed [DW-1:0] pos_x,
  input  logic signed [DW-1:0] pos_y,
  output logic busy,
  output logic done,
  output logic err,
  output logic signed [DW-1:0] sum,
  output logic signed [DW-1:0] sum_1hop,
  output logic signed [DW-1:0] max_len,
  output logic [EDGE_AW-1:0] err_edge
`ifdef PLACEMENT_EVAL_HIST_EN
  ,
  input  logic [2:0] hist_sel,
  output logic [DW-1:0] hist_cnt
`endif
);
  state_t state, state_nx;
  logic [EDGE_AW-1:0] idx;
  logic [POS_AW-1:0] b_r;
  logic signed [DW-1:0] xa_r, ya_r, len_r, len1_r;
  logic signed [DW-1:0] dx, dy, len, len_1hop;
  logic illegal;
  logic unused;
  assign unused = ^{edge_a[DW-1:POS_AW], edge_b[DW-1:POS_AW], dx, dy};
  edge_cost #(.DW(DW), .GRID_N(GRID_N)) u_cost (
    .xa(xa_r), .ya(ya_r), .xb(pos_x), .yb(pos_y),
    .dx(dx), .dy(dy), .len(len), .len_1hop(len_1hop), .illegal(illegal)
  );
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? RD_E : IDLE;
      RD_E: state_nx = W_E;
      W_E:  state_nx = RD_A;
      RD_A: state_nx = W_A;
      W_A:  state_nx = RD_B;
      RD_B: state_nx = W_B;
      W_B:  state_nx = CALC;
      CALC: state_nx = illegal ? DONE : ACC;
      ACC:  state_nx = idx == EDGE_AW'(N_EDGE - 1) ? DONE : RD_E;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Read strobes and addresses are registered so they are valid for exactly the RD_* cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      edge_re <= 1'b0;
      pos_re <= 1'b0;
      edge_addr <= '0;
      pos_addr <= '0;
      idx <= '0;
      b_r <= '0;
      xa_r <= '0;
      ya_r <= '0;
      len_r <= '0;
      len1_r <= '0;
      err <= 1'b0;
      err_edge <= '0;
      sum <= '0;
      sum_1hop <= '0;
      max_len <= '0;
    end else begin
      state <= state_nx;
      edge_re <= state_nx == RD_E;
      pos_re <= state_nx == RD_A || state_nx == RD_B;
      if (state_nx == RD_E) edge_addr <= state == IDLE ? '0 : idx + EDGE_AW'(1);
      if (state_nx == RD_A) pos_addr <= edge_a[POS_AW-1:0];
      if (state_nx == RD_B) pos_addr <= b_r;
      if (state == IDLE && start) begin
        idx <= '0;
        err <= 1'b0;
        err_edge <= '0;
        sum <= '0;
        sum_1hop <= '0;
        max_len <= '0;
      end
      if (state == RD_A) b_r <= edge_b[POS_AW-1:0];
      if (state == RD_B) begin
        xa_r <= pos_x;
        ya_r <= pos_y;
      end
      if (state == CALC) begin
        len_r <= len;
        len1_r <= len_1hop;
        if (illegal) begin
          err <= 1'b1;
          err_edge <= idx;
        end
      end
      if (state == ACC) begin
        sum <= sum + len_r - DW'(1);
        sum_1hop <= sum_1hop + len1_r;
        max_len <= len_r > max_len ? len_r : max_len;
        idx <= idx + EDGE_AW'(1);
      end
    end
  end
`ifdef PLACEMENT_EVAL_HIST_EN
  logic [DW-1:0] hist [8];
  logic [2:0] bin;
  assign bin = len_r > DW'(7) ? 3'd7 : len_r[2:0];
  assign hist_cnt = hist[hist_sel];
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      for (int i = 0; i < 8; i++) hist[i] <= '0;
    end else if (state == ACC) begin
      hist[bin] <= hist[bin] + DW'(1);
    end
  end
`endif
endmodule

// File: tb/tb_placement_eval.sv
// tb_placement_eval: directed scenarios for placement_eval with N_EDGE=2 and behavioural memories
module tb_placement_eval;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic edge_re, pos_re, busy, done, err;
  logic [7:0] edge_addr, err_edge;
  logic [6:0] pos_addr;
  logic signed [DW-1:0] edge_a = '0, edge_b = '0, pos_x = '0, pos_y = '0;
  logic signed [DW-1:0] sum, sum_1hop, max_len;
  logic signed [DW-1:0] ea [2], eb [2], px [8], py [8];
  int n_checks = 0;
  int n_errors = 0;
`ifdef PLACEMENT_EVAL_HIST_EN
  logic [2:0] hist_sel = '0;
  logic [DW-1:0] hist_cnt;
`endif
  always #5 clk = ~clk;
  placement_eval #(.N_EDGE(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .edge_re(edge_re), .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b),
    .pos_re(pos_re), .pos_addr(pos_addr), .pos_x(pos_x), .pos_y(pos_y),
    .busy(busy), .done(done), .err(err),
    .sum(sum), .sum_1hop(sum_1hop), .max_len(max_len), .err_edge(err_edge)
`ifdef PLACEMENT_EVAL_HIST_EN
    , .hist_sel(hist_sel), .hist_cnt(hist_cnt)
`endif
  );
  always @(posedge clk) begin
    if (edge_re) begin
      edge_a <= ea[edge_addr[0]];
      edge_b <= eb[edge_addr[0]];
    end
    if (pos_re) begin
      pos_x <= px[pos_addr[2:0]];
      pos_y <= py[pos_addr[2:0]];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic load(input int x2, input int y2);
    ea[0] = 0; eb[0] = 1; ea[1] = 1; eb[1] = 2;
    for (int i = 0; i < 8; i++) begin px[i] = 0; py[i] = 0; end
    px[1] = 3; py[1] = 2; px[2] = x2; py[2] = y2;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_re"}, {edge_re, pos_re}, 0);
    check({tag, "_addr"}, {edge_addr, pos_addr}, 0);
    check({tag, "_flags"}, {busy, done, err, err_edge}, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_res"}, {sum_1hop, max_len}, 0);
  endtask
  // Start in cycle 0, then watch cycles 1..40; optional stray start pulse and reset.
  task automatic run(input int pulse_at, input int rst_at, output int done_at, output int n_done,
                     output int b_first, output int b_last);
    done_at = -1; n_done = 0; b_first = -1; b_last = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == rst_at + 1) begin
        check_zero("mid_reset");
        reset = 1'b0;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (busy) begin
        if (b_first < 0) b_first = c;
        b_last = c;
      end
      start = c == pulse_at;
      if (c == rst_at) reset = 1'b1;
    end
  endtask
  int d_at, n_d, b_f, b_l;
  initial begin
    load(3, 3);
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    run(-1, -1, d_at, n_d, b_f, b_l);
    check("s1_sum", sum, 4);
    check("s1_sum_1hop", sum_1hop, 2);
    check("s1_max_len", max_len, 5);
    check("s1_err", err, 0);
    check("s1_done_cycle", d_at, 17);
    check("s1_done_count", n_d, 1);
    check("s1_busy_first", b_f, 1);
    check("s1_busy_last", b_l, 17);
`ifdef PLACEMENT_EVAL_HIST_EN
    for (int b = 0; b < 8; b++) begin
      hist_sel = 3'(b);
      #1;
      check("hist_bin", hist_cnt, (b == 1 || b == 5) ? 1 : 0);
    end
`endif
    load(-1, 3);
    run(-1, -1, d_at, n_d, b_f, b_l);
    check("unplaced_err", {err, err_edge}, {1'b1, 8'd1});
    check("unplaced_done_cycle", d_at, 16);
    check("unplaced_sum", sum, 4);
    check("unplaced_max_len", max_len, 5);
    load(3, 2);
    run(-1, -1, d_at, n_d, b_f, b_l);
    check("coincident_err", {err, err_edge}, {1'b1, 8'd1});
    check("coincident_sums", {sum, sum_1hop}, {32'sd4, 32'sd2});
    load(7, 3);
    run(-1, -1, d_at, n_d, b_f, b_l);
    check("offgrid_err", {err, err_edge}, {1'b1, 8'd1});
    load(6, 3);
    run(-1, -1, d_at, n_d, b_f, b_l);
    check("edge_of_grid_err", err, 0);
    check("edge_of_grid_sums", {sum, sum_1hop, max_len}, {32'sd7, 32'sd4, 32'sd5});
    load(3, 3);
    py[0] = -1;
    run(-1, -1, d_at, n_d, b_f, b_l);
    check("edge0_err", {err, err_edge}, {1'b1, 8'd0});
    check("edge0_done_cycle", d_at, 8);
    check("edge0_sum", sum, 0);
    load(3, 3);
    run(5, -1, d_at, n_d, b_f, b_l);
    check("busy_start_done_cycle", d_at, 17);
    check("busy_start_done_count", n_d, 1);
    check("busy_start_sums", {sum, sum_1hop, max_len}, {32'sd4, 32'sd2, 32'sd5});
    check("busy_start_err_cleared", err, 0);
    run(-1, 10, d_at, n_d, b_f, b_l);
    check("reset_run_done_count", n_d, 0);
    run(-1, -1, d_at, n_d, b_f, b_l);
    check("after_reset_sums", {sum, sum_1hop, max_len}, {32'sd4, 32'sd2, 32'sd5});
    check("after_reset_done_cycle", d_at, 17);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/placement_eval.md
# placement_eval

Post-placement wirelength evaluator. Sits directly downstream of the random placement engine. After placement finishes, it walks the edge-list ROMs (A/B endpoint pairs) and the position-X/Y RAMs. For every edge it computes the Manhattan cost, the 1-hop cost, the maximum edge length and a legality check. It then reports totals through a start/done handshake, so the placement engine no longer needs its own evaluation states.

## Interface
- `N_EDGE`, 52: number of edges to evaluate (addresses 0..N_EDGE-1).
- `GRID_N`, 7: grid side; a legal coordinate c satisfies 0 ≤ c < GRID_N.
- `EDGE_AW`, 8: edge ROM address width.
- `POS_AW`, 7: position RAM address width.
- `DW`, 32: data width; all coordinates and results are signed DW.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `start` in 1: begin evaluation; sampled only in IDLE.
- `edge_re` out 1: read enable, shared by the A and B edge ROMs.
- `edge_addr` out EDGE_AW: edge index.
- `edge_a`, `edge_b` in DW: endpoint node ids.
- `pos_re` out 1: read enable, shared by the X and Y position RAMs.
- `pos_addr` out POS_AW: node id.
- `pos_x`, `pos_y` in DW: node coordinates; -1 means unplaced.
- `busy` out 1: high from the cycle after start is accepted until the DONE cycle inclusive.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: illegal placement detected; sticky until the next start.
- `sum` out DW: Σ(dx+dy−1).
- `sum_1hop` out DW: Σ(⌈dx/2⌉+⌈dy/2⌉−1).
- `max_len` out DW: largest dx+dy seen.
- `err_edge` out EDGE_AW: index of the first offending edge.

## Operation
- FSM states: IDLE → RD_E → W_E → RD_A → W_A → RD_B → W_B → CALC → ACC, then either back to RD_E (next edge) or to DONE → IDLE.
- IDLE:
  - When start=1, clear sum, sum_1hop, max_len, err and err_edge; set index=0.
  - start is ignored in every other state.
- RD_E: drive edge_re=1 and edge_addr=index.
- RD_A: edge data is valid. Latch b. Drive pos_re=1 and pos_addr=edge_a.
- RD_B: latch (xa,ya) from pos_x/pos_y. Drive pos_re=1 and pos_addr=b.
- CALC:
  - Latch (xb,yb).
  - dx=|xa−xb| and dy=|ya−yb|, computed in two's complement. Absolute value is implemented as (~v)+1 when v<0.
- Legality check, applied in CALC; the first failure wins:
  - Failure: any coordinate is −1, any coordinate is ≥ GRID_N, or dx+dy==0 (two nodes in the same cell).
  - On failure: set err=1, err_edge=index, go directly to DONE.
  - A failing edge is not accumulated.
- ACC:
  - sum += dx+dy−1.
  - sum_1hop += (dx>>1)+dx[0]+(dy>>1)+dy[0]−1.
  - max_len = max(max_len, dx+dy).
  - index++.
  - If index==N_EDGE−1 before the increment, go to DONE; otherwise go to RD_E.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Results hold their values in IDLE until the next accepted start.
- Read enables are single-cycle pulses. Addresses hold their value until the next read.

## Timing
- Memories: data is valid on dout in the cycle after the cycle in which re is sampled high. Each W_* state absorbs that latency.
- Start is accepted in cycle 0.
- Edge k occupies cycles 1+8k .. 8+8k.
- DONE occurs in cycle 8·N_EDGE+1; for N_EDGE=52 that is cycle 417.
- An error on edge k produces DONE in cycle 8+8k.
- Reset values: edge_re=0, pos_re=0, all addresses 0, busy=0, done=0, err=0, all results 0, FSM=IDLE.
- A reset asserted mid-run takes effect on the next edge: outputs return to their reset values and no done pulse is produced.
- start held high across DONE does not retrigger until the FSM is back in IDLE. A new run is accepted in the cycle after DONE if start=1.

## Configuration
- `PLACEMENT_EVAL_HIST_EN`, when defined:
  - Adds input `hist_sel[2:0]` and output `hist_cnt[DW-1:0]`.
  - Keeps 8 counters. Bin = min(dx+dy, 7), incremented in ACC.
  - All counters are cleared on start and on reset.
  - hist_cnt is a combinational read of counter hist_sel.
- When not defined, the ports and counters are absent. Latency is identical either way.

## Structure
- Shared package `placement_pkg` holds:
  - the state enum;
  - `UNPLACED = -1`;
  - the default values of DW, GRID_N and N_EDGE, shared with the placement engine.
- One combinational sub-module, `edge_cost`:
  - inputs: xa, ya, xb, yb;
  - outputs: dx, dy, len, len_1hop, illegal.
- The FSM, accumulators and histogram stay in the top module.

## Test plan
- Basic run, N_EDGE=2:
  - Stimulus: node0=(0,0), node1=(3,2), node2=(3,3); edges (0,1),(1,2).
  - Required: sum=4, sum_1hop=2, max_len=5, err=0, done in cycle 17, busy high cycles 1–17.
- Unplaced node: node2 x=−1.
  - Required: err=1, err_edge=1, done in cycle 16, sum=4, max_len=5.
- Coincident nodes: node1=node2=(3,2).
  - Required: err=1, err_edge=1, edge 1 not accumulated.
- Start while busy: pulse start in cycle 5.
  - Required: ignored; single done in cycle 17; results unchanged.
- Reset mid-run: reset asserted in cycle 10.
  - Required: all outputs are 0 next cycle. A fresh start afterwards reproduces the scenario-1 results.
- `PLACEMENT_EVAL_HIST_EN` with the scenario-1 data.
  - Required: hist_cnt is 1 for bins 1 and 5 and 0 for all others.
